// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush control for the 5-stage MIPS pipeline.
//   Detects load-use and branch-operand hazards between the instruction in ID
//   and the producers in EX and MEM. A branch that needs a load result still
//   in EX stalls for two cycles, using a RUN/HOLD countdown FSM. Stall cycles
//   and IF/ID flushes are counted with saturating 16-bit counters.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   ReadRegister1/2             Rs/Rt of the instruction in ID
//   BranchID, BranchTaken       branch in ID and its comparator result
//   JumpID                      j/jal in ID
//   MemReadEX, RegWriteEX,
//   RegDstEX, RtEX, RdEX        ID/EX control and register fields
//   MemReadMEM, RegWriteMEM,
//   WriteRegMEM                 EX/MEM control and destination
//   PCWrite, IF_IDWrite         register enables (1 = may update)
//   ID_EXFlush, IF_IDFlush      bubble into ID/EX, nop into IF/ID
//   StallCycles, FlushCount     saturating statistics
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  input  logic        BranchID,
  input  logic        BranchTaken,
  input  logic        JumpID,
  input  logic        MemReadEX,
  input  logic        RegWriteEX,
  input  logic        RegDstEX,
  input  logic [4:0]  RtEX,
  input  logic [4:0]  RdEX,
  input  logic        MemReadMEM,
  input  logic        RegWriteMEM,
  input  logic [4:0]  WriteRegMEM,
  output logic        PCWrite,
  output logic        IF_IDWrite,
  output logic        ID_EXFlush,
  output logic        IF_IDFlush,
  output logic [15:0] StallCycles,
  output logic [15:0] FlushCount
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t     state, state_n;
  logic [1:0] remain, remain_n;
  logic [4:0] dest_ex;
  logic       m_rt, m_dest, m_mem;
  logic       need2, need1;
  logic       unused_regwrite_mem;

  // A load sitting in MEM is identified by MemReadMEM alone.
  assign unused_regwrite_mem = RegWriteMEM;

  assign dest_ex = RegDstEX ? RdEX : RtEX;

  // Register 0 is hardwired, so it never creates a dependency.
  assign m_rt   = (RtEX != 5'd0) &&
                  (RtEX == ReadRegister1 || RtEX == ReadRegister2);
  assign m_dest = (dest_ex != 5'd0) &&
                  (dest_ex == ReadRegister1 || dest_ex == ReadRegister2);
  assign m_mem  = (WriteRegMEM != 5'd0) &&
                  (WriteRegMEM == ReadRegister1 || WriteRegMEM == ReadRegister2);

  // Jump fields are not register operands, so a jump never stalls.
  assign need2 = !JumpID && BranchID && MemReadEX && m_rt;
  assign need1 = !JumpID && !need2 &&
                 ((MemReadEX && m_rt) ||
                  (BranchID && RegWriteEX && !MemReadEX && m_dest) ||
                  (BranchID && MemReadMEM && m_mem));

  always_comb begin
    state_n    = state;
    remain_n   = remain;
    PCWrite    = 1'b1;
    IF_IDWrite = 1'b1;
    ID_EXFlush = 1'b0;
    IF_IDFlush = 1'b0;
    if (!rst_n) begin
      PCWrite    = 1'b0;
      IF_IDWrite = 1'b0;
      ID_EXFlush = 1'b1;
      IF_IDFlush = 1'b1;
      state_n    = RUN;
      remain_n   = 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (need2 || need1) begin
            // A stall beats a taken branch; the branch re-resolves afterwards.
            PCWrite    = 1'b0;
            IF_IDWrite = 1'b0;
            ID_EXFlush = 1'b1;
            if (need2) begin
              state_n  = HOLD;
              remain_n = 2'd1;
            end
          end else begin
            IF_IDFlush = JumpID || (BranchID && BranchTaken);
          end
        end
        HOLD: begin
          PCWrite    = 1'b0;
          IF_IDWrite = 1'b0;
          ID_EXFlush = 1'b1;
          remain_n   = remain - 2'd1;
          if (remain <= 2'd1) begin
            state_n  = RUN;
            remain_n = 2'd0;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      remain <= 2'd0;
    end else begin
      state  <= state_n;
      remain <= remain_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCycles <= 16'd0;
      FlushCount  <= 16'd0;
    end else begin
      if (!PCWrite && StallCycles != 16'hFFFF) StallCycles <= StallCycles + 16'd1;
      if (IF_IDFlush && FlushCount != 16'hFFFF) FlushCount <= FlushCount + 16'd1;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard control for the 5-stage MIPS pipeline. Consumes the ID/EX pipeline register outputs and the EX/MEM destination fields, and drives the stall and flush controls back into the PC, IF/ID and ID/EX registers. It detects load-use and branch-operand hazards. It holds multi-cycle stalls with a small countdown FSM and keeps saturating stall and flush statistics.

## Interface
- no parameters
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- ReadRegister1, ReadRegister2  in  5 each  Rs and Rt of the instruction in ID
- BranchID  in  1  beq/bne in ID (operands compared in ID)
- BranchTaken  in  1  ID comparator result; valid only when BranchID=1
- JumpID  in  1  j/jal in ID
- MemReadEX, RegWriteEX, RegDstEX  in  1 each  ID/EX control outputs
- RtEX, RdEX  in  5 each  ID/EX register fields
- MemReadMEM, RegWriteMEM  in  1 each  EX/MEM control
- WriteRegMEM  in  5  EX/MEM destination register
- PCWrite  out  1  1 = PC may update
- IF_IDWrite  out  1  1 = IF/ID may load
- ID_EXFlush  out  1  1 = ID/EX loads zero controls (bubble)
- IF_IDFlush  out  1  1 = IF/ID loads nop
- StallCycles  out  16  saturating count of stall cycles
- FlushCount  out  16  saturating count of IF/ID flushes

## Operation
- DestEX = RegDstEX ? RdEX : RtEX. Matching register 0 never counts as a hazard.
- `match(r)` is true when r != 0 and (r == ReadRegister1 or r == ReadRegister2).
- Required stall cycles `need`:
  - need = 2: BranchID & MemReadEX & match(RtEX).
  - need = 1: the branch-load case above does not apply, and any of the following holds:
    - MemReadEX & match(RtEX) (load-use)
    - BranchID & RegWriteEX & !MemReadEX & match(DestEX)
    - BranchID & MemReadMEM & match(WriteRegMEM)
  - need = 0: otherwise.
- JumpID=1 forces need = 0, because jump fields are not register operands.
- FSM states: RUN and HOLD, with a 2-bit counter `remain`.
  - RUN, need=0: PCWrite=1, IF_IDWrite=1, ID_EXFlush=0. IF_IDFlush = JumpID | (BranchID & BranchTaken). Stay in RUN.
  - RUN, need>=1: PCWrite=0, IF_IDWrite=0, ID_EXFlush=1, IF_IDFlush=0.
    - need=1: stay in RUN.
    - need=2: go to HOLD with remain=1.
  - HOLD: PCWrite=0, IF_IDWrite=0, ID_EXFlush=1, IF_IDFlush=0. Hazard inputs are ignored. remain decrements each cycle. When remain==1, go to RUN.
- Re-evaluation after leaving HOLD happens normally in RUN. The producer has advanced, so no residual stall is expected.
- Simultaneous events:
  - Stall plus BranchTaken: the stall wins and no flush occurs. The branch re-resolves after the stall.
  - Stall plus JumpID: impossible, since JumpID forces need=0.
- Counters:
  - StallCycles increments on every cycle with PCWrite=0 while rst_n=1.
  - FlushCount increments on every cycle with IF_IDFlush=1.
  - Both saturate at 16'hFFFF.

## Timing
- Outputs in RUN are combinational (Mealy) from the current inputs, in the same cycle. Outputs in HOLD are decoded from state only.
- Load-use costs 1 bubble. Branch after ALU costs 1. Branch after load in EX costs 2. Branch after load in MEM costs 1.
- Reset (rst_n=0, asynchronous):
  - State goes to RUN, remain=0, StallCycles=0, FlushCount=0.
  - While rst_n=0, outputs are forced: PCWrite=0, IF_IDWrite=0, ID_EXFlush=1, IF_IDFlush=1.
- Reset asserted during HOLD aborts the stall immediately. After rst_n rises, the first edge evaluates from RUN.
- Counter updates take effect on the rising edge following the counted cycle.

## Test plan
- **Load-use:** lw $2 in EX (MemReadEX=1, RtEX=2) with add reading $2 in ID (ReadRegister1=2) -> one cycle of PCWrite=0, IF_IDWrite=0, ID_EXFlush=1; StallCycles becomes 1.
- **Branch after load:** BranchID=1, ReadRegister2=5, MemReadEX=1, RtEX=5 -> exactly 2 stall cycles (RUN to HOLD to RUN). BranchTaken=1 held throughout gives no flush during the stall and one IF_IDFlush cycle afterward. End state: StallCycles=2, FlushCount=1.
- **Register 0 and jump:** MemReadEX=1 with RtEX=0 and ReadRegister1=0 -> no stall. JumpID=1 with RtEX matching -> no stall, IF_IDFlush=1.
- **Branch after ALU:** BranchID=1, RegWriteEX=1, RegDstEX=1, RdEX=7, ReadRegister1=7 -> 1 stall. The same case with RegDstEX=0 and RtEX=9 -> no stall.
- **Reset mid-stall:** enter HOLD, then drop rst_n mid-cycle -> outputs go to the forced reset values immediately and both counters read 0. After release, with no hazard on the inputs: PCWrite=1.
- **Saturation:** force a continuous load-use for 65540 cycles -> StallCycles holds at 16'hFFFF.
